// File: rtl/reg_file_alu_pkg.sv
// rtl/reg_file_alu_pkg.sv - shared op encodings, flag struct and shift-width helper
package reg_file_alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SHL = 3'b110,
        ALU_SHR = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } alu_flags_t;

    function automatic int shamt_w(input int data_w);
        return $clog2(data_w);
    endfunction

endpackage

// File: rtl/reg_file_alu_core.sv
// rtl/reg_file_alu_core.sv - combinational eight-op ALU with zero/negative/carry/overflow flags
module alu_core
    import reg_file_alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result,
    output alu_flags_t        flags
);

    localparam int SHAMT_W = shamt_w(DATA_W);

    logic [DATA_W:0]    sum;
    logic [DATA_W:0]    diff;
    logic [SHAMT_W-1:0] shamt;

    assign sum   = {1'b0, a} + {1'b0, b};
    // The borrow out of the widened subtraction is exactly unsigned a < b.
    assign diff  = {1'b0, a} - {1'b0, b};
    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        result         = '0;
        flags.carry    = 1'b0;
        flags.overflow = 1'b0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: begin
                result         = sum[DATA_W-1:0];
                flags.carry    = sum[DATA_W];
                flags.overflow = (a[DATA_W-1] == b[DATA_W-1]) &&
                                 (sum[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                result         = diff[DATA_W-1:0];
                flags.carry    = diff[DATA_W];
                flags.overflow = (a[DATA_W-1] != b[DATA_W-1]) &&
                                 (diff[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SHL: result = a << shamt;
            ALU_SHR: result = a >> shamt;
        endcase
        flags.zero     = (result == '0);
        flags.negative = result[DATA_W-1];
    end

endmodule

// File: rtl/reg_file_alu_pipe.sv
// rtl/reg_file_alu_pipe.sv - two-stage register-file/ALU pipeline with bypass and output backpressure
module reg_file_alu_pipe
    import reg_file_alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     RA1,
    input  logic [AW-1:0]     RA2,
    input  logic [AW-1:0]     WA,
    input  logic              write_enable,
    input  logic              ALUSrc,
    input  logic [2:0]        ALUControl,
    input  logic [DATA_W-1:0] immediate,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALUResult,
    output logic              Zero,
    output logic              Negative,
    output logic              Carry,
    output logic              Overflow,
    output logic [DATA_W-1:0] cpu_out
);

    logic [DATA_W-1:0] regs [NREGS];

    logic              ex_valid;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    alu_op_e           ex_op;
    logic [AW-1:0]     ex_wa;
    logic              ex_we;

    logic [DATA_W-1:0] alu_res;
    alu_flags_t        alu_flg;
    alu_flags_t        out_flags;

    logic              ex_advance;
    logic              issue;
    logic              ex_writes;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] src_b;

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .a      (ex_a),
        .b      (ex_b),
        .op     (ex_op),
        .result (alu_res),
        .flags  (alu_flg)
    );

    assign ex_advance = ex_valid && (!out_valid || out_ready);
    assign in_ready   = !ex_valid || ex_advance;
    assign issue      = in_valid && in_ready;
    assign ex_writes  = ex_advance && ex_we && (ex_wa != '0);

    // The retiring result is written on the same edge the next instruction
    // captures its operands, so it must be forwarded around the register file.
    always_comb begin
        rd1 = '0;
        if (ex_writes && (RA1 == ex_wa)) begin
            rd1 = alu_res;
        end else if (RA1 != '0) begin
            rd1 = regs[RA1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (ex_writes && (RA2 == ex_wa)) begin
            rd2 = alu_res;
        end else if (RA2 != '0) begin
            rd2 = regs[RA2];
        end
    end

    assign src_b = ALUSrc ? immediate : rd2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (ex_writes) begin
            regs[ex_wa] <= alu_res;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_valid  <= 1'b0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_op     <= ALU_AND;
            ex_wa     <= '0;
            ex_we     <= 1'b0;
            out_valid <= 1'b0;
            ALUResult <= '0;
            out_flags <= '0;
        end else begin
            if (issue) begin
                ex_valid <= 1'b1;
                ex_a     <= rd1;
                ex_b     <= src_b;
                ex_op    <= alu_op_e'(ALUControl);
                ex_wa    <= WA;
                ex_we    <= write_enable;
            end else if (ex_advance) begin
                ex_valid <= 1'b0;
            end

            if (ex_advance) begin
                out_valid <= 1'b1;
                ALUResult <= alu_res;
                out_flags <= alu_flg;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign Zero     = out_flags.zero;
    assign Negative = out_flags.negative;
    assign Carry    = out_flags.carry;
    assign Overflow = out_flags.overflow;
    assign cpu_out  = regs[NREGS-1];

endmodule
